apb_req_arbiter: RTL and testbench

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_ctrl_pkg.sv | 15 +
 rtl/apb_rr_arbiter.sv | 17 +
 rtl/apb_req_arbiter.sv | 163 ++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_ctrl_pkg.sv
// Shared types and widths for the two-requester APB master.
package apb_ctrl_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin grant: one-hot grant among valid requesters while advance_i is high;
// on contention the requester that was not granted last wins.
module apb_rr_arbiter
  import apb_ctrl_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  input  req_id_t    last_i,
  output logic [1:0] grant_o
);

  for (genvar gi = 0; gi < 2; gi++) begin : g_grant
    assign grant_o[gi] = advance_i & valid_i[gi] &
                         (~valid_i[1-gi] | (last_i != req_id_t'(gi)));
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Arbitrates two request ports onto one APB master (IDLE/SETUP/ACCESS).
// Define APB_TIMEOUT_EN to end ACCESS with an error after TIMEOUT_CYCLES wait states.
module apb_req_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp0_err,
  output logic              rsp1_err,
  output logic              psel1,
  output logic              psel2,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_e        state_q, state_d;
  req_id_t           owner_q, owner_d;
  req_id_t           last_q, last_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [1:0]        grant;
  logic              timeout;
  logic              active;

  apb_rr_arbiter u_rr (
    .valid_i   ({req1_valid, req0_valid}),
    .advance_i ((state_q == IDLE) & ~preset),
    .last_i    (last_q),
    .grant_o   (grant)
  );

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == SETUP) begin
      wait_cnt_d = '0;
    end else if ((state_q == ACCESS) && !pready) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end

  // The last tolerated wait state is the one where the count equals TIMEOUT_CYCLES-1.
  assign timeout = (state_q == ACCESS) && !pready &&
                   (32'(wait_cnt_q) == TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          owner_d = grant[1];
          last_d  = grant[1];
          write_d = grant[1] ? req1_write : req0_write;
          addr_d  = grant[1] ? req1_addr  : req0_addr;
          wdata_d = grant[1] ? req1_wdata : req0_wdata;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready || timeout) begin
          state_d              = IDLE;
          rsp_valid_d[owner_q] = 1'b1;
          if (timeout) begin
            rsp_err_d = 1'b1;
          end else begin
            rsp_err_d   = pslverr;
            rsp_rdata_d = write_q ? '0 : prdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign active     = (state_q == SETUP) || (state_q == ACCESS);
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign psel1      = active & ~addr_q[ADDR_W-1];
  assign psel2      = active &  addr_q[ADDR_W-1];
  assign penable    = (state_q == ACCESS);
  assign pwrite     = active & write_q;
  assign paddr      = active ? addr_q  : '0;
  assign pwdata     = active ? wdata_q : '0;

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_rdata = rsp_valid_q[0] ? rsp_rdata_q : '0;
  assign rsp1_rdata = rsp_valid_q[1] ? rsp_rdata_q : '0;
  assign rsp0_err   = rsp_valid_q[0] & rsp_err_q;
  assign rsp1_err   = rsp_valid_q[1] & rsp_err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: scoreboard of expected responses plus an APB slave model.
module tb_apb_req_arbiter;

  logic       pclk, preset;
  logic       req0_valid, req0_write, req1_valid, req1_write;
  logic [8:0] req0_addr, req1_addr;
  logic [7:0] req0_wdata, req1_wdata;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic       psel1, psel2, penable, pwrite, pready, pslverr;
  logic [8:0] paddr;
  logic [7:0] pwdata, prdata;

  typedef struct packed { logic id; logic [7:0] rdata; logic err; } exp_t;
  exp_t sb[$];
  exp_t exp_e;
  logic got_id, got_err;
  logic [7:0] got_rdata;

  int checks = 0;
  int errors = 0;
  int sl_wait = 0;
  int sl_wcnt = 0;
  logic [7:0] sl_rdata = 8'h00;
  logic sl_err = 1'b0;
  logic sl_stuck = 1'b0;
  int acc_cnt = 0;
  int last_acc_len = 0;
  logic [1:0] last_sel = 2'b00;

  apb_req_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .pclk(pclk), .preset(preset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_rdata(rsp0_rdata), .rsp1_rdata(rsp1_rdata),
    .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
    .psel1(psel1), .psel2(psel2), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // APB slave: pready after sl_wait wait states, never while sl_stuck.
  initial begin
    pready = 1'b0; prdata = 8'h00; pslverr = 1'b0;
    forever begin
      @(posedge pclk); #1;
      if (penable) begin
        pready  = !sl_stuck && (sl_wcnt >= sl_wait);
        prdata  = sl_rdata;
        pslverr = pready & sl_err;
        sl_wcnt++;
      end else begin
        pready = 1'b0; prdata = 8'h00; pslverr = 1'b0; sl_wcnt = 0;
      end
    end
  end

  // Monitor: protocol invariants every cycle, scoreboard compare on each response pulse.
  initial begin
    forever begin
      @(negedge pclk);
      if (penable) begin
        acc_cnt++;
        last_sel = {psel2, psel1};
      end else if (acc_cnt != 0) begin
        last_acc_len = acc_cnt;
        acc_cnt = 0;
      end
      if (!preset) begin
        checks++;
        if ((psel1 && psel2) || (rsp0_valid && rsp1_valid) ||
            (!(psel1 || psel2) && (paddr != '0 || pwdata != '0 || pwrite || penable)) ||
            (!rsp0_valid && (rsp0_rdata != '0 || rsp0_err)) ||
            (!rsp1_valid && (rsp1_rdata != '0 || rsp1_err))) begin
          errors++;
          $display("FAIL invariant: psel=%b%b rsp=%b%b paddr=%h pwdata=%h pwrite=%b penable=%b rd0=%h e0=%b rd1=%h e1=%b, required exclusive selects/pulses and zero idle outputs",
                   psel2, psel1, rsp1_valid, rsp0_valid, paddr, pwdata, pwrite, penable,
                   rsp0_rdata, rsp0_err, rsp1_rdata, rsp1_err);
        end
      end
      if (rsp0_valid || rsp1_valid) begin
        checks++;
        got_id    = rsp1_valid;
        got_rdata = rsp1_valid ? rsp1_rdata : rsp0_rdata;
        got_err   = rsp1_valid ? rsp1_err : rsp0_err;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got id=%0d rdata=%h err=%0d, required no response", got_id, got_rdata, got_err);
        end else begin
          exp_e = sb.pop_front();
          if (got_id !== exp_e.id || got_rdata !== exp_e.rdata || got_err !== exp_e.err) begin
            errors++;
            $display("FAIL rsp_check: got id=%0d rdata=%h err=%0d, required id=%0d rdata=%h err=%0d",
                     got_id, got_rdata, got_err, exp_e.id, exp_e.rdata, exp_e.err);
          end else begin
            $display("rsp id=%0d rdata=%h err=%0d", got_id, got_rdata, got_err);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic expect_rsp(input logic id, input logic [7:0] rd, input logic err);
    sb.push_back({id, rd, err});
  endtask

  // Call at posedge+1; returns at posedge+1 just after acceptance.
  task automatic drive_req(input logic id, input logic wr, input logic [8:0] a, input logic [7:0] d);
    logic ok;
    ok = 1'b0;
    if (id) begin
      req1_write = wr; req1_addr = a; req1_wdata = d; req1_valid = 1'b1;
    end else begin
      req0_write = wr; req0_addr = a; req0_wdata = d; req0_valid = 1'b1;
    end
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge pclk);
      if (id ? req1_ready : req0_ready) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_req%0d: ready never seen within 200 cycles, required acceptance", id);
    end else begin
      @(posedge pclk); #1;
    end
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge pclk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
    tick(1);
  endtask

  task automatic test_reset();
    preset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick(3);
    @(negedge pclk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 00", {req0_ready, req1_ready});
    end
    checks++;
    if ({psel1, psel2, penable, pwrite, paddr, pwdata, rsp0_valid, rsp1_valid,
         rsp0_rdata, rsp1_rdata, rsp0_err, rsp1_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: psel=%b%b penable=%b paddr=%h rsp=%b%b, required all 0",
               psel2, psel1, penable, paddr, rsp1_valid, rsp0_valid);
    end
    @(posedge pclk); #1;
    preset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    tick(1);
  endtask

  task automatic test_single_write();
    sl_wait = 0; sl_rdata = 8'h11;
    expect_rsp(1'b0, 8'h00, 1'b0);
    req0_write = 1'b1; req0_addr = 9'h012; req0_wdata = 8'hA5; req0_valid = 1'b1;
    @(negedge pclk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL write_grant: ready0/1=%b, required 10", {req0_ready, req1_ready});
    end
    @(posedge pclk); #1;
    req0_valid = 1'b0;
    @(negedge pclk);
    checks++;
    if ({psel1, psel2, penable, pwrite} !== 4'b1001 || paddr !== 9'h012 || pwdata !== 8'hA5) begin
      errors++;
      $display("FAIL write_setup: sel/en/wr=%b paddr=%h pwdata=%h, required 1001 012 a5",
               {psel1, psel2, penable, pwrite}, paddr, pwdata);
    end
    @(negedge pclk);
    checks++;
    if ({psel1, psel2, penable, pwrite} !== 4'b1011 || paddr !== 9'h012 || pwdata !== 8'hA5) begin
      errors++;
      $display("FAIL write_access: sel/en/wr=%b paddr=%h pwdata=%h, required 1011 012 a5",
               {psel1, psel2, penable, pwrite}, paddr, pwdata);
    end
    @(negedge pclk);
    checks++;
    if ({rsp0_valid, psel1, penable} !== 3'b100) begin
      errors++;
      $display("FAIL write_rsp_timing: rsp0/psel1/penable=%b, required 100", {rsp0_valid, psel1, penable});
    end
    @(negedge pclk);
    checks++;
    if (rsp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_rsp_pulse: rsp0_valid=%b a cycle later, required 0", rsp0_valid);
    end
    @(posedge pclk); #1;
    wait_drain();
  endtask

  task automatic test_read_wait();
    sl_wait = 3; sl_rdata = 8'h3C;
    expect_rsp(1'b1, 8'h3C, 1'b0);
    drive_req(1'b1, 1'b0, 9'h105, 8'h00);
    wait_drain();
    checks++;
    if (last_acc_len !== 4 || last_sel !== 2'b10) begin
      errors++;
      $display("FAIL read_wait: access cycles=%0d sel=%b, required 4 and 10", last_acc_len, last_sel);
    end
    sl_wait = 0;
  endtask

  task automatic test_contention();
    preset = 1'b1;
    tick(2);
    preset = 1'b0;
    tick(1);
    sl_rdata = 8'h77;
    for (int k = 0; k < 4; k++) begin
      expect_rsp(1'b0, 8'h77, 1'b0);
      expect_rsp(1'b1, 8'h00, 1'b0);
    end
    fork
      begin
        for (int k = 0; k < 4; k++) drive_req(1'b0, 1'b0, 9'(48 + k), 8'h00);
      end
      begin
        for (int j = 0; j < 4; j++) drive_req(1'b1, 1'b1, 9'(320 + j), 8'(192 + j));
      end
    join
    wait_drain();
  endtask

  task automatic test_slave_error();
    sl_err = 1'b1; sl_rdata = 8'h99;
    expect_rsp(1'b0, 8'h99, 1'b1);
    drive_req(1'b0, 1'b0, 9'h020, 8'h00);
    wait_drain();
    sl_err = 1'b0;
  endtask

  task automatic test_reset_abort();
    sl_stuck = 1'b1;
    drive_req(1'b1, 1'b0, 9'h0F0, 8'h00);
    @(negedge pclk);
    @(negedge pclk);
    checks++;
    if (penable !== 1'b1 || pready !== 1'b0) begin
      errors++;
      $display("FAIL abort_wait_state: penable=%b pready=%b, required 1 0", penable, pready);
    end
    preset = 1'b1;
    @(posedge pclk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge pclk);
    checks++;
    if ({req0_ready, req1_ready, psel1, psel2, penable, pwrite, paddr, pwdata, rsp0_valid,
         rsp1_valid, rsp0_rdata, rsp1_rdata, rsp0_err, rsp1_err} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: ready=%b%b psel=%b%b penable=%b paddr=%h rsp=%b%b, required all 0",
               req1_ready, req0_ready, psel2, psel1, penable, paddr, rsp1_valid, rsp0_valid);
    end
    @(posedge pclk); #1;
    preset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    sl_stuck = 1'b0; sl_rdata = 8'h42;
    expect_rsp(1'b0, 8'h42, 1'b0);
    expect_rsp(1'b1, 8'h00, 1'b0);
    fork
      drive_req(1'b0, 1'b0, 9'h011, 8'h00);
      drive_req(1'b1, 1'b1, 9'h111, 8'h5E);
    join
    wait_drain();
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    sl_stuck = 1'b1; sl_rdata = 8'hEE;
    expect_rsp(1'b0, 8'h00, 1'b1);
    drive_req(1'b0, 1'b0, 9'h050, 8'h00);
    wait_drain();
    checks++;
    if (last_acc_len !== 4) begin
      errors++;
      $display("FAIL timeout_len: access cycles=%0d, required 4", last_acc_len);
    end
    sl_stuck = 1'b0;
    expect_rsp(1'b1, 8'hEE, 1'b0);
    drive_req(1'b1, 1'b0, 9'h150, 8'h00);
    wait_drain();
  endtask
`endif

  initial begin
    preset = 1'b1;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
    test_reset();
    test_single_write();
    test_read_wait();
    test_contention();
    test_slave_error();
    test_reset_abort();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
